// File: rtl/alu_pkg.sv
// Shared types for the iterative multiply/divide unit: operation encoding,
// FSM states and a small op-class helper.
package alu_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // The top bit of the encoding separates the divide family from multiplies.
  function automatic logic is_div(muldiv_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Restoring divider datapath: one quotient bit per step on unsigned magnitudes.
// The next quotient/remainder are exposed so the top can finish on the last step.
module alu_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo_next,
  output logic [WIDTH-1:0] rem_next
);

  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // A borrow out of the trial subtraction means the divisor did not fit.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    if (diff[WIDTH]) begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
    end else if (step) begin
      quo <= quo_next;
      rem <= rem_next;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit, one bit per cycle.
// Define ALU_DIV_EN to build the divider; otherwise divide ops return 0 in one cycle.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_e             state, state_next;
  muldiv_op_e         op_in, op_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   ma;
  logic [2*WIDTH-1:0] prod, prod_next, prod_fix;
  logic [WIDTH:0]     psum;
  logic               accept, neg_q, neg_in;
  logic               a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               fast_done;
  logic [WIDTH-1:0]   fast_result, final_result;

  assign op_in  = muldiv_op_e'(op);
  assign accept = in_valid && in_ready;

`ifdef ALU_DIV_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic [WIDTH-1:0] quo_next, rem_next;
  logic             div_zero, div_ovf;

  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     (state == CALC && !flush),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = fast_done ? DONE : CALC;
      CALC:    if (flush) state_next = IDLE;
               else if (cnt == '0) state_next = DONE;
      DONE:    if (flush || out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rst_n && (state == IDLE) && !flush;
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Operands are iterated as magnitudes; the final negation flag fixes the sign.
  always_comb begin
    a_signed = op_in inside {MULH, MULHSU, DIV, REM};
    b_signed = op_in inside {MULH, DIV, REM};
    a_neg    = a_signed && rs1[WIDTH-1];
    b_neg    = b_signed && rs2[WIDTH-1];
    a_mag    = a_neg ? -rs1 : rs1;
    b_mag    = b_neg ? -rs2 : rs2;
    neg_in   = 1'b0;
    case (op_in)
      MULH, MULHSU, DIV: neg_in = a_neg ^ b_neg;
      REM:               neg_in = a_neg;
      default:           neg_in = 1'b0;
    endcase
  end

  always_comb begin
    fast_done   = 1'b0;
    fast_result = '0;
`ifdef ALU_DIV_EN
    div_zero = (rs2 == '0);
    div_ovf  = (op_in == DIV || op_in == REM) && (rs1 == MOST_NEG) && (rs2 == '1);
    if (is_div(op_in) && div_zero) begin
      fast_done   = 1'b1;
      fast_result = (op_in == DIV || op_in == DIVU) ? '1 : rs1;
    end else if (div_ovf) begin
      fast_done   = 1'b1;
      fast_result = (op_in == DIV) ? rs1 : '0;
    end
`else
    fast_done = is_div(op_in);
`endif
  end

  // Shift-add: conditionally add the multiplicand to the upper half, shift right.
  always_comb begin
    psum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, ma} : '0);
    prod_next = {psum, prod[WIDTH-1:1]};
    prod_fix  = neg_q ? -prod_next : prod_next;
    final_result = (op_q == MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
`ifdef ALU_DIV_EN
    if (op_q == DIV || op_q == DIVU)
      final_result = neg_q ? -quo_next : quo_next;
    else if (op_q == REM || op_q == REMU)
      final_result = neg_q ? -rem_next : rem_next;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= MUL;
      cnt    <= '0;
      ma     <= '0;
      prod   <= '0;
      neg_q  <= 1'b0;
      result <= '0;
    end else if (accept) begin
      op_q  <= op_in;
      cnt   <= CW'(WIDTH - 1);
      ma    <= a_mag;
      prod  <= {{WIDTH{1'b0}}, b_mag};
      neg_q <= neg_in;
      if (fast_done) result <= fast_result;
    end else if (state == CALC && !flush) begin
      cnt  <= (cnt != '0) ? cnt - 1'b1 : '0;
      prod <= prod_next;
      if (cnt == '0) result <= final_result;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed vector table, randomized ops
// against an arithmetic reference model, and stall/reset/flush sequences.
module tb_alu_muldiv;
  import alu_pkg::*;

`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  alu_muldiv #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(logic [2:0] o, logic [31:0] a, logic [31:0] b,
                                 logic [31:0] e, int l);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.exp = e; v.lat = l;
    return v;
  endfunction

  function automatic logic [31:0] refModel(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    longint      sa, sb, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      default: begin
        if (!DIV_EN) return 32'h0;
        if (b == 32'h0) return (o == 3'd4 || o == 3'd5) ? 32'hFFFF_FFFF : a;
        if ((o == 3'd4 || o == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF)
          return (o == 3'd4) ? a : 32'h0;
        case (o)
          3'd4: q = sa / sb;
          3'd5: q = longint'(a) / longint'(b);
          3'd6: q = sa % sb;
          default: q = longint'(a) % longint'(b);
        endcase
        return q[31:0];
      end
    endcase
  endfunction

  function automatic int refLat(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    if (o < 3'd4) return 33;
    if (!DIV_EN) return 1;
    if (b == 32'h0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one op and wait (bounded) for out_valid; latency counts cycles after accept.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] res, output int lat);
    @(negedge clk);
    in_valid = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic startOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drainOutput();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] exp_v;
    int          lat;
    logic [2:0]  o;
    logic [31:0] a, b;
    int          sel;
    bit          seen;

    // Reset state while rst_n is held low
    #1;
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("reset_result", result, 32'h0);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_reset_in_ready", {31'b0, in_ready}, 32'h1);

    vecs.push_back(mkVec(MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33));
    vecs.push_back(mkVec(MULH,   MIN_NEG,      MIN_NEG,       32'h4000_0000, 33));
    vecs.push_back(mkVec(MULHU,  MIN_NEG,      MIN_NEG,       32'h4000_0000, 33));
    vecs.push_back(mkVec(MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 33));
    vecs.push_back(mkVec(MUL,    32'h1234_5678, 32'h10,       32'h2345_6780, 33));
    vecs.push_back(mkVec(MULHU,  32'd3,        32'd5,         32'h0,         33));
    vecs.push_back(mkVec(DIVU,   32'd100,      32'd0,  DIV_EN ? 32'hFFFF_FFFF : 32'h0, 1));
    vecs.push_back(mkVec(REMU,   32'd100,      32'd0,  DIV_EN ? 32'd100 : 32'h0, 1));
    vecs.push_back(mkVec(DIV,    MIN_NEG,      32'hFFFF_FFFF, DIV_EN ? MIN_NEG : 32'h0, 1));
    vecs.push_back(mkVec(REM,    MIN_NEG,      32'hFFFF_FFFF, 32'h0, 1));
    vecs.push_back(mkVec(DIV,    32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFD : 32'h0, DIV_EN ? 33 : 1));
    vecs.push_back(mkVec(REM,    32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFF : 32'h0, DIV_EN ? 33 : 1));
    vecs.push_back(mkVec(DIVU,   32'd9,        32'd3,  DIV_EN ? 32'd3 : 32'h0, DIV_EN ? 33 : 1));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      checkOutput($sformatf("vec%0d_result", i), res, vecs[i].exp);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      drainOutput();
    end

    // Randomized ops, biased toward the divide corner cases
    for (int i = 0; i < 40; i++) begin
      o   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'h0;
      if (sel == 1) begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
      if (sel == 2) b = 32'($urandom_range(1, 15));
      if (sel == 3) a = 32'($urandom_range(0, 100));
      applyStimulus(o, a, b, res, lat);
      checkOutput($sformatf("rand%0d_op%0d_result", i, o), res, refModel(o, a, b));
      checkOutput($sformatf("rand%0d_op%0d_latency", i, o), 32'(lat), 32'(refLat(o, a, b)));
      drainOutput();
    end

    // Consumer stall: result and out_valid hold, no new accept
    exp_v = DIV_EN ? 32'hFFFF_FFFD : 32'h0;
    applyStimulus(DIV, 32'hFFFF_FFF9, 32'd2, res, lat);
    checkOutput("stall_first_result", res, exp_v);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; op = MUL; rs1 = 32'd1; rs2 = 32'd1;
      @(posedge clk); #1;
      checkOutput($sformatf("stall%0d_out_valid", k), {31'b0, out_valid}, 32'h1);
      checkOutput($sformatf("stall%0d_result", k), result, exp_v);
      checkOutput($sformatf("stall%0d_in_ready", k), {31'b0, in_ready}, 32'h0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drainOutput();
    checkOutput("stall_release_busy", {31'b0, busy}, 32'h0);

    // Asynchronous reset in the middle of a calculation
    applyStimulus(MUL, 32'd7, 32'd3, res, lat);
    checkOutput("pre_reset_result", res, 32'd21);
    drainOutput();
    startOp(MUL, 32'd1234, 32'd5678);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("async_reset_result", result, 32'h0);
    checkOutput("async_reset_busy", {31'b0, busy}, 32'h0);
    in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("hold_reset%0d_result", k), result, 32'h0);
      checkOutput($sformatf("hold_reset%0d_busy", k), {31'b0, busy}, 32'h0);
      checkOutput($sformatf("hold_reset%0d_out_valid", k), {31'b0, out_valid}, 32'h0);
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; rst_n = 1'b1;
    #1;
    checkOutput("release_in_ready", {31'b0, in_ready}, 32'h1);
    applyStimulus(MULHU, 32'd3, 32'd5, res, lat);
    checkOutput("after_reset_mulhu_result", res, 32'h0);
    checkOutput("after_reset_mulhu_latency", 32'(lat), 32'd33);
    drainOutput();

    // Flush mid-calculation with a competing request in the same cycle
    startOp(MUL, 32'd5, 32'd5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = DIVU; rs1 = 32'd9; rs2 = 32'd0;
    #1;
    checkOutput("flush_in_ready", {31'b0, in_ready}, 32'h0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush_busy", {31'b0, busy}, 32'h0);
    checkOutput("flush_out_valid", {31'b0, out_valid}, 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("flush_no_out_valid", {31'b0, seen}, 32'h0);
    checkOutput("flush_result_kept", result, 32'h0);
    applyStimulus(MUL, 32'd6, 32'd7, res, lat);
    checkOutput("after_flush_result", res, 32'd42);
    checkOutput("after_flush_latency", 32'(lat), 32'd33);
    drainOutput();

    // Flush asserted in IDLE together with in_valid must not accept
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = MUL; rs1 = 32'd2; rs2 = 32'd2;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("idle_flush_busy", {31'b0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
